// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between instruction fetch (IF) and
// data memory (DM). DM has priority; a starvation counter forces an IF win.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LAT     = 1,
   parameter int MAX_IF_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [2:0] LAT_CNT  = 3'(MEM_LAT);
   localparam logic [3:0] WAIT_MAX = 4'(MAX_IF_WAIT);

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                owner_q, owner_d;
   logic [3:0]          if_wait_q, if_wait_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                if_gnt_q, if_gnt_d;
   logic                dm_gnt_q, dm_gnt_d;
   logic                if_rvalid_q, if_rvalid_d;
   logic                dm_rvalid_q, dm_rvalid_d;
   logic                win_if;

   // IF only beats a concurrent DM request once it has lost MAX_IF_WAIT times in a row
   always_comb begin
      win_if = if_req && (!dm_req || (if_wait_q == WAIT_MAX));
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      if_wait_d   = if_wait_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (!if_req || win_if) begin
               if_wait_d = 4'd0;
            end else if (if_wait_q != WAIT_MAX) begin
               if_wait_d = if_wait_q + 4'd1;
            end

            if (if_req || dm_req) begin
               state_d  = ACCESS;
               cnt_d    = LAT_CNT;
               owner_d  = !win_if;
               mem_en_d = 1'b1;
               if (win_if) begin
                  if_gnt_d    = 1'b1;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
               end else begin
                  dm_gnt_d    = 1'b1;
                  mem_we_d    = dm_we;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
               end
            end
         end

         ACCESS: begin
            if (cnt_q == 3'd1) begin
               state_d     = IDLE;
               if_rvalid_d = !owner_q;
               dm_rvalid_d = owner_q;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         owner_q     <= 1'b0;
         if_wait_q   <= 4'd0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         if_wait_q   <= if_wait_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_gnt_q    <= if_gnt_d;
         dm_gnt_q    <= dm_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign dm_gnt    = dm_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign dm_rvalid = dm_rvalid_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q == ACCESS);
   assign if_rdata  = mem_rdata;
   assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at MEM_LAT 1, 2 and 3 driven
// from per-cycle vector tables; the memory returns a fixed function of the address.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [2:0]  ir, dr, dw;
   logic [31:0] ia [3];
   logic [31:0] da [3];
   logic [31:0] dd [3];
   wire  [2:0]  ig, irv, dg, drv, men, mwe, bsy;
   wire  [2:0][31:0] ird, drd, maddr, mwd, mrd;
   logic [31:0] lat_addr [3];

   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_port_arbiter #(
         .ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1), .MAX_IF_WAIT((g == 0) ? 2 : 4)
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .if_req(ir[g]), .if_addr(ia[g]), .if_gnt(ig[g]), .if_rvalid(irv[g]), .if_rdata(ird[g]),
         .dm_req(dr[g]), .dm_we(dw[g]), .dm_addr(da[g]), .dm_wdata(dd[g]),
         .dm_gnt(dg[g]), .dm_rvalid(drv[g]), .dm_rdata(drd[g]),
         .mem_en(men[g]), .mem_we(mwe[g]), .mem_addr(maddr[g]), .mem_wdata(mwd[g]),
         .mem_rdata(mrd[g]), .busy(bsy[g])
      );
      assign mrd[g] = mem_fn(lat_addr[g]);
   end

   // Memory model: latch the address of each access; data holds until the next one
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (men[i]) lat_addr[i] <= maddr[i];
      end
   end

   localparam logic [5:0] IG = 6'b100000, DG = 6'b010000, IRV = 6'b001000;
   localparam logic [5:0] DRV = 6'b000100, MEN = 6'b000010, BSY = 6'b000001;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dd;
      logic [5:0]  ctl;
      logic [31:0] maddr;
      logic [31:0] mwd;
      logic        mwe;
      logic        rd_chk;
      logic [31:0] rd;
   } row_t;

   function automatic row_t R(input logic i_r, input logic [31:0] i_a, input logic d_r,
                              input logic d_w, input logic [31:0] d_a, input logic [31:0] d_d,
                              input logic [5:0] c, input logic [31:0] m_a, input logic [31:0] m_d,
                              input logic m_w, input logic r_c, input logic [31:0] r_d);
      row_t r;
      r.ir = i_r; r.ia = i_a; r.dr = d_r; r.dw = d_w; r.da = d_a; r.dd = d_d;
      r.ctl = c; r.maddr = m_a; r.mwd = m_d; r.mwe = m_w; r.rd_chk = r_c; r.rd = r_d;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic run_row(input int u, input row_t r, input string tag);
      logic [5:0] got;
      @(posedge clk);
      #1;
      ir[u] = r.ir; ia[u] = r.ia; dr[u] = r.dr; dw[u] = r.dw; da[u] = r.da; dd[u] = r.dd;
      @(negedge clk);
      got = {ig[u], dg[u], irv[u], drv[u], men[u], bsy[u]};
      chk({tag, " ctl{ig,dg,irv,drv,en,busy}"}, {26'd0, got}, {26'd0, r.ctl});
      if (r.ctl[1]) begin
         chk({tag, " mem_addr"}, maddr[u], r.maddr);
         chk({tag, " mem_wdata"}, mwd[u], r.mwd);
         chk({tag, " mem_we"}, {31'd0, mwe[u]}, {31'd0, r.mwe});
      end
      if (r.rd_chk) begin
         if (r.ctl[3]) chk({tag, " if_rdata"}, ird[u], r.rd);
         else          chk({tag, " dm_rdata"}, drd[u], r.rd);
      end
   endtask

   task automatic chk_zero(input int u, input string tag);
      chk({tag, " ctl"}, {26'd0, ig[u], dg[u], irv[u], drv[u], men[u], bsy[u]}, 32'd0);
      chk({tag, " mem_we"}, {31'd0, mwe[u]}, 32'd0);
      chk({tag, " mem_addr"}, maddr[u], 32'd0);
      chk({tag, " mem_wdata"}, mwd[u], 32'd0);
   endtask

   row_t v1 [$];
   row_t v2 [$];
   row_t v3a [$];
   row_t v3b [$];

   initial begin
      // LAT=1, MAX_IF_WAIT=2: simultaneous, starvation, store, back-to-back
      v1.push_back(R(1, 32'h300, 1, 0, 32'h200, 0, 0,               0,       0, 0, 0, 0));
      v1.push_back(R(1, 32'h300, 1, 0, 32'h200, 0, DG|MEN|BSY,      32'h200, 0, 0, 0, 0));
      v1.push_back(R(1, 32'h300, 0, 0, 0,       0, DRV,             0,       0, 0, 1, 32'h5A5A0200));
      v1.push_back(R(1, 32'h300, 0, 0, 0,       0, IG|MEN|BSY,      32'h300, 0, 0, 0, 0));
      v1.push_back(R(0, 0,       0, 0, 0,       0, IRV,             0,       0, 0, 1, 32'h5A5A0300));
      v1.push_back(R(1, 32'h104, 1, 0, 32'h210, 0, 0,               0,       0, 0, 0, 0));
      v1.push_back(R(1, 32'h104, 1, 0, 32'h210, 0, DG|MEN|BSY,      32'h210, 0, 0, 0, 0));
      v1.push_back(R(1, 32'h104, 1, 0, 32'h214, 0, DRV,             0,       0, 0, 1, 32'h5A5A0210));
      v1.push_back(R(1, 32'h104, 1, 0, 32'h214, 0, DG|MEN|BSY,      32'h214, 0, 0, 0, 0));
      v1.push_back(R(1, 32'h104, 1, 0, 32'h218, 0, DRV,             0,       0, 0, 1, 32'h5A5A0214));
      v1.push_back(R(1, 32'h104, 1, 0, 32'h218, 0, IG|MEN|BSY,      32'h104, 0, 0, 0, 0));
      v1.push_back(R(1, 32'h108, 1, 0, 32'h218, 0, IRV,             0,       0, 0, 1, 32'h5A5A0104));
      v1.push_back(R(1, 32'h108, 1, 0, 32'h218, 0, DG|MEN|BSY,      32'h218, 0, 0, 0, 0));
      v1.push_back(R(1, 32'h108, 0, 0, 0,       0, DRV,             0,       0, 0, 1, 32'h5A5A0218));
      v1.push_back(R(1, 32'h108, 0, 0, 0,       0, IG|MEN|BSY,      32'h108, 0, 0, 0, 0));
      v1.push_back(R(0, 0,       0, 0, 0,       0, IRV,             0,       0, 0, 1, 32'h5A5A0108));
      v1.push_back(R(0, 0,       0, 0, 0,       0, 0,               0,       0, 0, 0, 0));
      v1.push_back(R(0, 0, 1, 1, 32'h40, 32'h1234, 0,               0,       0, 0, 0, 0));
      v1.push_back(R(0, 0, 1, 1, 32'h40, 32'h1234, DG|MEN|BSY, 32'h40, 32'h1234, 1, 0, 0));
      v1.push_back(R(0, 0,       0, 0, 0,       0, DRV,             0,       0, 0, 0, 0));
      v1.push_back(R(0, 0,       0, 0, 0,       0, 0,               0,       0, 0, 0, 0));
      v1.push_back(R(0, 0,       1, 0, 32'h280, 0, 0,               0,       0, 0, 0, 0));
      v1.push_back(R(0, 0,       1, 0, 32'h280, 0, DG|MEN|BSY,      32'h280, 0, 0, 0, 0));
      v1.push_back(R(0, 0,       1, 0, 32'h284, 0, DRV,             0,       0, 0, 1, 32'h5A5A0280));
      v1.push_back(R(0, 0,       1, 0, 32'h284, 0, DG|MEN|BSY,      32'h284, 0, 0, 0, 0));
      v1.push_back(R(0, 0,       1, 0, 32'h288, 0, DRV,             0,       0, 0, 1, 32'h5A5A0284));
      v1.push_back(R(0, 0,       1, 0, 32'h288, 0, DG|MEN|BSY,      32'h288, 0, 0, 0, 0));
      v1.push_back(R(0, 0,       1, 0, 32'h28C, 0, DRV,             0,       0, 0, 1, 32'h5A5A0288));
      v1.push_back(R(0, 0,       1, 0, 32'h28C, 0, DG|MEN|BSY,      32'h28C, 0, 0, 0, 0));
      v1.push_back(R(0, 0,       0, 0, 0,       0, DRV,             0,       0, 0, 1, 32'h5A5A028C));
      v1.push_back(R(0, 0,       0, 0, 0,       0, 0,               0,       0, 0, 0, 0));
      // LAT=2: single fetch
      v2.push_back(R(1, 32'h100, 0, 0, 0, 0, 0,          0,       0, 0, 0, 0));
      v2.push_back(R(1, 32'h100, 0, 0, 0, 0, IG|MEN|BSY, 32'h100, 0, 0, 0, 0));
      v2.push_back(R(0, 0,       0, 0, 0, 0, BSY,        0,       0, 0, 0, 0));
      v2.push_back(R(0, 0,       0, 0, 0, 0, IRV,        0,       0, 0, 1, 32'hDEADBEEF));
      v2.push_back(R(0, 0,       0, 0, 0, 0, 0,          0,       0, 0, 0, 0));
      // LAT=3: load granted, then reset while in flight
      v3a.push_back(R(0, 0, 1, 0, 32'h3C0, 0, 0,          0,       0, 0, 0, 0));
      v3a.push_back(R(0, 0, 1, 0, 32'h3C0, 0, DG|MEN|BSY, 32'h3C0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) v3b.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      v3b.push_back(R(1, 32'h120, 0, 0, 0, 0, 0,          0,       0, 0, 0, 0));
      v3b.push_back(R(1, 32'h120, 0, 0, 0, 0, IG|MEN|BSY, 32'h120, 0, 0, 0, 0));
      v3b.push_back(R(0, 0,       0, 0, 0, 0, BSY,        0,       0, 0, 0, 0));
      v3b.push_back(R(0, 0,       0, 0, 0, 0, BSY,        0,       0, 0, 0, 0));
      v3b.push_back(R(0, 0,       0, 0, 0, 0, IRV,        0,       0, 0, 1, 32'h5A5A0120));
      v3b.push_back(R(0, 0,       0, 0, 0, 0, 0,          0,       0, 0, 0, 0));

      rst_n = 1'b0;
      ir = '0; dr = '0; dw = '0;
      for (int i = 0; i < 3; i++) begin
         ia[i] = '0; da[i] = '0; dd[i] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_zero(i, $sformatf("reset u%0d", i));
      rst_n = 1'b1;

      foreach (v1[i]) run_row(0, v1[i], $sformatf("lat1 row%0d", i));
      foreach (v2[i]) run_row(1, v2[i], $sformatf("lat2 row%0d", i));
      foreach (v3a[i]) run_row(2, v3a[i], $sformatf("lat3 pre row%0d", i));

      // cycle after dm_gnt: still in flight, then reset clears everything at once
      @(posedge clk);
      #1;
      chk("midreset busy before", {31'd0, bsy[2]}, 32'd1);
      rst_n = 1'b0;
      dr[2] = 1'b0;
      #1;
      chk_zero(2, "midreset async");
      @(posedge clk);
      @(negedge clk);
      chk_zero(2, "midreset held");
      rst_n = 1'b1;
      foreach (v3b[i]) run_row(2, v3b[i], $sformatf("lat3 post row%0d", i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
